delta_calc: RTL and testbench

DELTA_CALC -- requirements
Module: delta_calc

---
 rtl/delta_calc.sv | 138 +++++++++++++
 tb/tb_delta_calc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_calc.sv
// Delta (first-derivative) cepstral coefficients: 4-deep per-index history, 2-stage pipeline.
// Optional macro DELTA_SAT_EN: saturate the result to 16 bits instead of wrapping.
module delta_calc #(
  parameter int NUM_CEP = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] cep_in,
  input  logic               cep_valid,
  input  logic               delta_clr,
  output logic signed [15:0] delta_out,
  output logic               delta_valid,
  output logic [3:0]         delta_idx,
  output logic               warm
);

  // Valid semantics: cep_valid is a one-cycle qualifier with no backpressure; every
  // accepted sample updates history, and delta_valid pulses once per result, two
  // cycles later, only for samples accepted while warm. delta_clr wins over cep_valid.
  localparam logic [3:0] LAST_IDX = 4'(NUM_CEP - 1);

  logic [3:0]         r_k;
  logic [2:0]         r_frames;
  logic signed [15:0] r_h1 [NUM_CEP];
  logic signed [15:0] r_h2 [NUM_CEP];
  logic signed [15:0] r_h3 [NUM_CEP];
  logic signed [15:0] r_h4 [NUM_CEP];

  logic               w_accept;
  logic               w_last;
  logic signed [15:0] w_h1;
  logic signed [15:0] w_h3;
  logic signed [15:0] w_h4;
  logic signed [18:0] w_num;
  logic signed [15:0] w_red;

  logic signed [18:0] r_s1_num;
  logic [3:0]         r_s1_idx;
  logic               r_s1_valid;

  assign w_accept = cep_valid & ~delta_clr;
  assign w_last   = (r_k == LAST_IDX);
  assign warm     = (r_frames == 3'd4);

  assign w_h1 = r_h1[r_k];
  assign w_h3 = r_h3[r_k];
  assign w_h4 = r_h4[r_k];

  // 19 bits hold the worst case 3*65535 without overflow.
  assign w_num = ({{3{cep_in[15]}}, cep_in} - {{3{w_h4[15]}}, w_h4})
               + (({{3{w_h1[15]}}, w_h1} - {{3{w_h3[15]}}, w_h3}) <<< 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k      <= '0;
      r_frames <= '0;
    end else if (delta_clr) begin
      r_k      <= '0;
      r_frames <= '0;
    end else if (cep_valid) begin
      r_k <= w_last ? 4'd0 : r_k + 4'd1;
      if (w_last && !warm) begin
        r_frames <= r_frames + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CEP; i++) begin
        r_h1[i] <= '0;
        r_h2[i] <= '0;
        r_h3[i] <= '0;
        r_h4[i] <= '0;
      end
    end else if (delta_clr) begin
      for (int i = 0; i < NUM_CEP; i++) begin
        r_h1[i] <= '0;
        r_h2[i] <= '0;
        r_h3[i] <= '0;
        r_h4[i] <= '0;
      end
    end else if (cep_valid) begin
      r_h1[r_k] <= cep_in;
      r_h2[r_k] <= r_h1[r_k];
      r_h3[r_k] <= r_h2[r_k];
      r_h4[r_k] <= r_h3[r_k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_num   <= '0;
      r_s1_idx   <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept & warm;
      if (w_accept && warm) begin
        r_s1_num <= w_num;
        r_s1_idx <= r_k;
      end
    end
  end

`ifdef DELTA_SAT_EN
  logic signed [18:0] w_res;
  assign w_res = r_s1_num >>> 2;

  always_comb begin
    w_red = w_res[15:0];
    if (w_res > 19'sd32767) begin
      w_red = 16'sh7FFF;
    end else if (w_res < -19'sd32768) begin
      w_red = 16'sh8000;
    end
  end
`else
  assign w_red = 16'(r_s1_num >>> 2);
`endif

  // Output data holds its last value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delta_out   <= '0;
      delta_idx   <= '0;
      delta_valid <= 1'b0;
    end else if (delta_clr) begin
      delta_valid <= 1'b0;
    end else begin
      delta_valid <= r_s1_valid;
      if (r_s1_valid) begin
        delta_out <= w_red;
        delta_idx <= r_s1_idx;
      end
    end
  end

endmodule

// File: tb/tb_delta_calc.sv
// Directed self-checking bench for delta_calc (NUM_CEP = 13); honours DELTA_SAT_EN for expectations.
module tb_delta_calc;

  localparam int NC = 13;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] cep_in = '0;
  logic               cep_valid = 1'b0;
  logic               delta_clr = 1'b0;
  logic signed [15:0] delta_out;
  logic               delta_valid;
  logic [3:0]         delta_idx;
  logic               warm;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] obs_out[$];
  logic [3:0]  obs_idx[$];
  logic [15:0] exp_q[$];
  logic [3:0]  exp_idx_q[$];

  delta_calc #(.NUM_CEP(NC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cep_in     (cep_in),
    .cep_valid  (cep_valid),
    .delta_clr  (delta_clr),
    .delta_out  (delta_out),
    .delta_valid(delta_valid),
    .delta_idx  (delta_idx),
    .warm       (warm)
  );

  // ---------------- clock / monitor ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (delta_valid !== 1'b0) begin
      obs_out.push_back(delta_out);
      obs_idx.push_back(delta_idx);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] v);
    @(negedge clk);
    cep_valid = 1'b1;
    delta_clr = 1'b0;
    cep_in    = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cep_valid = 1'b0;
      delta_clr = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] v);
    for (int i = 0; i < NC; i++) send(v);
  endtask

  task automatic clear_all();
    @(negedge clk);
    cep_valid = 1'b0;
    delta_clr = 1'b1;
    idle(3);
    obs_out.delete();
    obs_idx.delete();
    exp_q.delete();
    exp_idx_q.delete();
  endtask

  task automatic push_exp(input logic [15:0] v, input int idx);
    exp_q.push_back(v);
    exp_idx_q.push_back(4'(idx));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_checks++; if (delta_out !== 16'd0) begin n_errors++; $display("FAIL reset_out: got %h want 0000", delta_out); end
    n_checks++; if (delta_idx !== 4'd0) begin n_errors++; $display("FAIL reset_idx: got %0d want 0", delta_idx); end
    n_checks++; if (delta_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", delta_valid); end
    n_checks++; if (warm !== 1'b0) begin n_errors++; $display("FAIL reset_warm: got %b want 0", warm); end
    rst_n = 1'b1;
  endtask

  task automatic test_constant();
    for (int f = 0; f < 3; f++) send_frame(16'd100);
    idle(3);
    n_checks++; if (warm !== 1'b0) begin n_errors++; $display("FAIL const_warm3: got %b want 0", warm); end
    send_frame(16'd100);
    idle(3);
    n_checks++; if (warm !== 1'b1) begin n_errors++; $display("FAIL const_warm4: got %b want 1", warm); end
    n_checks++; if (obs_out.size() != 0) begin n_errors++; $display("FAIL const_early: got %0d pulses want 0", obs_out.size()); end
    send_frame(16'd100);
    send_frame(16'd100);
    idle(4);
    for (int f = 0; f < 2; f++) for (int i = 0; i < NC; i++) push_exp(16'd0, i);
    n_checks++; if (obs_out.size() != exp_q.size()) begin n_errors++; $display("FAIL const_count: got %0d want %0d", obs_out.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_out.size(); i++) begin
      n_checks++; if (obs_out[i] !== exp_q[i]) begin n_errors++; $display("FAIL const_out[%0d]: got %h want %h", i, obs_out[i], exp_q[i]); end
      n_checks++; if (obs_idx[i] !== exp_idx_q[i]) begin n_errors++; $display("FAIL const_idx[%0d]: got %0d want %0d", i, obs_idx[i], exp_idx_q[i]); end
    end
  endtask

  task automatic test_ramp();
    clear_all();
    for (int f = 1; f <= 6; f++) send_frame(16'(8 * f));
    idle(4);
    for (int f = 0; f < 2; f++) for (int i = 0; i < NC; i++) push_exp(16'd16, i);
    n_checks++; if (obs_out.size() != exp_q.size()) begin n_errors++; $display("FAIL ramp_count: got %0d want %0d", obs_out.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_out.size(); i++) begin
      n_checks++; if (obs_out[i] !== exp_q[i]) begin n_errors++; $display("FAIL ramp_out[%0d]: got %h want %h", i, obs_out[i], exp_q[i]); end
      n_checks++; if (obs_idx[i] !== exp_idx_q[i]) begin n_errors++; $display("FAIL ramp_idx[%0d]: got %0d want %0d", i, obs_idx[i], exp_idx_q[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] sat_exp;
`ifdef DELTA_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'hBFFF;
`endif
    clear_all();
    // idx 0: h4 = h3 = -32768, h2 = 0, h1 = x0 = 32767
    for (int i = 0; i < NC; i++) send((i == 0) ? 16'h8000 : 16'h0000);
    for (int i = 0; i < NC; i++) send((i == 0) ? 16'h8000 : 16'h0000);
    send_frame(16'h0000);
    for (int i = 0; i < NC; i++) send((i == 0) ? 16'h7FFF : 16'h0000);
    for (int i = 0; i < NC; i++) send((i == 0) ? 16'h7FFF : 16'h0000);
    idle(4);
    push_exp(sat_exp, 0);
    for (int i = 1; i < NC; i++) push_exp(16'd0, i);
    n_checks++; if (obs_out.size() != exp_q.size()) begin n_errors++; $display("FAIL sat_count: got %0d want %0d", obs_out.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_out.size(); i++) begin
      n_checks++; if (obs_out[i] !== exp_q[i]) begin n_errors++; $display("FAIL sat_out[%0d]: got %h want %h", i, obs_out[i], exp_q[i]); end
      n_checks++; if (obs_idx[i] !== exp_idx_q[i]) begin n_errors++; $display("FAIL sat_idx[%0d]: got %0d want %0d", i, obs_idx[i], exp_idx_q[i]); end
    end
  endtask

  task automatic test_negative_floor();
    clear_all();
    for (int f = 0; f < 4; f++) send_frame(16'h0000);
    for (int i = 0; i < NC; i++) send((i == 5) ? 16'hFFFF : 16'h0000);
    idle(4);
    for (int i = 0; i < NC; i++) push_exp((i == 5) ? 16'hFFFF : 16'h0000, i);
    n_checks++; if (obs_out.size() != exp_q.size()) begin n_errors++; $display("FAIL neg_count: got %0d want %0d", obs_out.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_out.size(); i++) begin
      n_checks++; if (obs_out[i] !== exp_q[i]) begin n_errors++; $display("FAIL neg_out[%0d]: got %h want %h", i, obs_out[i], exp_q[i]); end
      n_checks++; if (obs_idx[i] !== exp_idx_q[i]) begin n_errors++; $display("FAIL neg_idx[%0d]: got %0d want %0d", i, obs_idx[i], exp_idx_q[i]); end
    end
  endtask

  task automatic test_clear();
    clear_all();
    for (int f = 1; f <= 5; f++) send_frame(16'(8 * f));
    for (int i = 0; i < 3; i++) send(16'd48);
    // clear collides with a valid sample: sample dropped, idx 2 result flushed
    @(negedge clk);
    cep_valid = 1'b1;
    delta_clr = 1'b1;
    cep_in    = 16'd999;
    idle(1);
    n_checks++; if (warm !== 1'b0) begin n_errors++; $display("FAIL clr_warm: got %b want 0", warm); end
    n_checks++; if (delta_valid !== 1'b0) begin n_errors++; $display("FAIL clr_valid: got %b want 0", delta_valid); end
    idle(3);
    for (int i = 0; i < NC; i++) push_exp(16'd16, i);
    push_exp(16'd16, 0);
    push_exp(16'd16, 1);
    n_checks++; if (obs_out.size() != exp_q.size()) begin n_errors++; $display("FAIL clr_pre_count: got %0d want %0d", obs_out.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_out.size(); i++) begin
      n_checks++; if (obs_out[i] !== exp_q[i]) begin n_errors++; $display("FAIL clr_pre_out[%0d]: got %h want %h", i, obs_out[i], exp_q[i]); end
      n_checks++; if (obs_idx[i] !== exp_idx_q[i]) begin n_errors++; $display("FAIL clr_pre_idx[%0d]: got %0d want %0d", i, obs_idx[i], exp_idx_q[i]); end
    end
    obs_out.delete(); obs_idx.delete(); exp_q.delete(); exp_idx_q.delete();
    for (int f = 0; f < 4; f++) send_frame(16'd7);
    idle(3);
    n_checks++; if (obs_out.size() != 0) begin n_errors++; $display("FAIL clr_rewarm: got %0d pulses want 0", obs_out.size()); end
    send_frame(16'd7);
    idle(4);
    for (int i = 0; i < NC; i++) push_exp(16'd0, i);
    n_checks++; if (obs_out.size() != exp_q.size()) begin n_errors++; $display("FAIL clr_post_count: got %0d want %0d", obs_out.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_out.size(); i++) begin
      n_checks++; if (obs_out[i] !== exp_q[i]) begin n_errors++; $display("FAIL clr_post_out[%0d]: got %h want %h", i, obs_out[i], exp_q[i]); end
      n_checks++; if (obs_idx[i] !== exp_idx_q[i]) begin n_errors++; $display("FAIL clr_post_idx[%0d]: got %0d want %0d", i, obs_idx[i], exp_idx_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_all();
    for (int f = 1; f <= 4; f++) send_frame(16'(8 * f));
    for (int i = 0; i < 3; i++) send(16'd40);
    @(negedge clk);
    cep_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (delta_out !== 16'd0) begin n_errors++; $display("FAIL rst_mid_out: got %h want 0000", delta_out); end
    n_checks++; if (delta_idx !== 4'd0) begin n_errors++; $display("FAIL rst_mid_idx: got %0d want 0", delta_idx); end
    n_checks++; if (delta_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_valid: got %b want 0", delta_valid); end
    n_checks++; if (warm !== 1'b0) begin n_errors++; $display("FAIL rst_mid_warm: got %b want 0", warm); end
    @(negedge clk);
    n_checks++; if (delta_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_hold: got %b want 0", delta_valid); end
    // release together with the first sample: it must be taken on the first edge
    @(negedge clk);
    rst_n     = 1'b1;
    cep_valid = 1'b1;
    cep_in    = 16'd5;
    for (int i = 1; i < 5 * NC; i++) send(16'd5);
    idle(4);
    push_exp(16'd16, 0);
    push_exp(16'd16, 1);
    for (int i = 0; i < NC; i++) push_exp(16'd0, i);
    n_checks++; if (obs_out.size() != exp_q.size()) begin n_errors++; $display("FAIL rst_mid_count: got %0d want %0d", obs_out.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_out.size(); i++) begin
      n_checks++; if (obs_out[i] !== exp_q[i]) begin n_errors++; $display("FAIL rst_mid_out[%0d]: got %h want %h", i, obs_out[i], exp_q[i]); end
      n_checks++; if (obs_idx[i] !== exp_idx_q[i]) begin n_errors++; $display("FAIL rst_mid_idx[%0d]: got %0d want %0d", i, obs_idx[i], exp_idx_q[i]); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_saturation();
    test_negative_floor();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
